// File: rtl/bus_arbiter_2m.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_2m
// Brief    : Two-master round-robin arbiter for the req/ack bus, with slave timeout.
// Revision : 1.0
// ============================================================================
module bus_arbiter_2m #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_cmd,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_cmd,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        s_req,
  output logic        s_cmd,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_ack,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  localparam logic [31:0] c_ERR_DATA = 32'hDEAD_BEEF;
  localparam logic [7:0]  c_TO_LAST  = 8'(TIMEOUT - 1);

  state_t      r_state, w_state;
  logic        r_prio, w_prio;
  logic [7:0]  r_cnt, w_cnt;
  logic        r_s_req, w_s_req;
  logic        r_s_cmd, w_s_cmd;
  logic [31:0] r_s_addr, w_s_addr;
  logic [31:0] r_s_wdata, w_s_wdata;
  logic [1:0]  r_grant, w_grant;
  logic        r_ack0, w_ack0;
  logic        r_ack1, w_ack1;
  logic        r_err, w_err;
  logic [31:0] r_rdata0, w_rdata0;
  logic [31:0] r_rdata1, w_rdata1;
  logic        w_sel1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_prio    <= 1'b0;
      r_cnt     <= 8'd0;
      r_s_req   <= 1'b0;
      r_s_cmd   <= 1'b0;
      r_s_addr  <= 32'd0;
      r_s_wdata <= 32'd0;
      r_grant   <= 2'b00;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_err     <= 1'b0;
      r_rdata0  <= 32'd0;
      r_rdata1  <= 32'd0;
    end else begin
      r_state   <= w_state;
      r_prio    <= w_prio;
      r_cnt     <= w_cnt;
      r_s_req   <= w_s_req;
      r_s_cmd   <= w_s_cmd;
      r_s_addr  <= w_s_addr;
      r_s_wdata <= w_s_wdata;
      r_grant   <= w_grant;
      r_ack0    <= w_ack0;
      r_ack1    <= w_ack1;
      r_err     <= w_err;
      r_rdata0  <= w_rdata0;
      r_rdata1  <= w_rdata1;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_prio    = r_prio;
    w_cnt     = r_cnt;
    w_s_req   = r_s_req;
    w_s_cmd   = r_s_cmd;
    w_s_addr  = r_s_addr;
    w_s_wdata = r_s_wdata;
    w_grant   = r_grant;
    w_ack0    = 1'b0;
    w_ack1    = 1'b0;
    w_err     = 1'b0;
    w_rdata0  = r_rdata0;
    w_rdata1  = r_rdata1;
    w_sel1    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          // A lone requester wins outright; prio only breaks ties.
          w_sel1    = (m0_req && m1_req) ? r_prio : m1_req;
          w_s_cmd   = w_sel1 ? m1_cmd   : m0_cmd;
          w_s_addr  = w_sel1 ? m1_addr  : m0_addr;
          w_s_wdata = w_sel1 ? m1_wdata : m0_wdata;
          w_grant   = w_sel1 ? 2'b10 : 2'b01;
          w_s_req   = 1'b1;
          w_cnt     = 8'd0;
          w_state   = S_BUSY;
        end
      end

      S_BUSY: begin
        if (s_ack) begin
          w_s_req = 1'b0;
          if (r_grant[1]) begin
            w_ack1 = 1'b1;
            if (!r_s_cmd) w_rdata1 = s_rdata;
          end else begin
            w_ack0 = 1'b1;
            if (!r_s_cmd) w_rdata0 = s_rdata;
          end
          w_prio  = r_grant[0];
          w_state = S_RELEASE;
        end else if (r_cnt == c_TO_LAST) begin
          w_s_req = 1'b0;
          w_err   = 1'b1;
          if (r_grant[1]) begin
            w_ack1   = 1'b1;
            w_rdata1 = c_ERR_DATA;
          end else begin
            w_ack0   = 1'b1;
            w_rdata0 = c_ERR_DATA;
          end
          w_prio  = ~r_prio;
          w_state = S_RELEASE;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end

      S_RELEASE: begin
        // Unconditional return to IDLE keeps a just-acked request from being re-granted.
        w_grant = 2'b00;
        w_state = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign s_req    = r_s_req;
  assign s_cmd    = r_s_cmd;
  assign s_addr   = r_s_addr;
  assign s_wdata  = r_s_wdata;
  assign grant    = r_grant;
  assign m0_ack   = r_ack0;
  assign m1_ack   = r_ack1;
  assign err      = r_err;
  assign m0_rdata = r_rdata0;
  assign m1_rdata = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_2m.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter_2m
// Brief    : Directed vector table plus hand sequences for bus_arbiter_2m.
// Revision : 1.0
// ============================================================================
module tb_bus_arbiter_2m;

  localparam logic [31:0] c_A0 = 32'h0000_0CE2;
  localparam logic [31:0] c_W0 = 32'h0000_0345;
  localparam logic [31:0] c_A1 = 32'h0000_5A50;
  localparam logic [31:0] c_W1 = 32'h0000_0777;
  localparam int          c_NV = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_cmd, m0_ack;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_cmd, m1_ack;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        s_req, s_cmd, s_ack, err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [1:0]  grant;

  int n_total = 0;
  int n_bad   = 0;

  bus_arbiter_2m #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata),
    .grant(grant), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, r0, c0, r1, c1, sack;
    logic [31:0] srd;
    logic        e_sreq;
    logic [1:0]  e_grant;
    logic        e_ack0, e_ack1, e_err, e_scmd;
    logic [31:0] e_saddr, e_swdata, e_rd0, e_rd1;
  } vec_t;

  vec_t vecs [c_NV];

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [134:0] outs();
    return {s_req, grant, m0_ack, m1_ack, err, s_cmd, s_addr, s_wdata, m0_rdata, m1_rdata};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int err_seen;
    int ack_seen;
    logic got;

    // rst r0 c0 r1 c1 sack srd | sreq grant ack0 ack1 err scmd saddr swdata rd0 rd1
    vecs[0]  = '{1,1,1,0,0,0,32'h0,          1,2'b01,0,0,0,1,c_A0,c_W0,32'h0,32'h0};
    vecs[1]  = '{1,1,1,0,0,0,32'h0,          1,2'b01,0,0,0,1,c_A0,c_W0,32'h0,32'h0};
    vecs[2]  = '{1,1,1,0,0,1,32'h5555_5555,  0,2'b01,1,0,0,1,c_A0,c_W0,32'h0,32'h0};
    vecs[3]  = '{1,0,0,0,0,0,32'h0,          0,2'b00,0,0,0,1,c_A0,c_W0,32'h0,32'h0};
    vecs[4]  = '{1,0,0,1,0,0,32'h0,          1,2'b10,0,0,0,0,c_A1,c_W1,32'h0,32'h0};
    vecs[5]  = '{1,0,0,1,0,1,32'h1234_5678,  0,2'b10,0,1,0,0,c_A1,c_W1,32'h0,32'h1234_5678};
    vecs[6]  = '{1,0,0,0,0,0,32'h0,          0,2'b00,0,0,0,0,c_A1,c_W1,32'h0,32'h1234_5678};
    vecs[7]  = '{1,0,0,0,0,1,32'hFFFF_0000,  0,2'b00,0,0,0,0,c_A1,c_W1,32'h0,32'h1234_5678};
    vecs[8]  = '{1,1,0,0,0,0,32'h0,          1,2'b01,0,0,0,0,c_A0,c_W0,32'h0,32'h1234_5678};
    vecs[9]  = '{1,1,0,0,0,1,32'hCAFE_0001,  0,2'b01,1,0,0,0,c_A0,c_W0,32'hCAFE_0001,32'h1234_5678};
    vecs[10] = '{1,0,0,0,0,1,32'h9999_9999,  0,2'b00,0,0,0,0,c_A0,c_W0,32'hCAFE_0001,32'h1234_5678};
    vecs[11] = '{1,0,0,0,0,1,32'h1111_1111,  0,2'b00,0,0,0,0,c_A0,c_W0,32'hCAFE_0001,32'h1234_5678};
    vecs[12] = '{0,0,0,0,0,0,32'h0,          0,2'b00,0,0,0,0,32'h0,32'h0,32'h0,32'h0};
    vecs[13] = '{1,0,0,0,0,0,32'h0,          0,2'b00,0,0,0,0,32'h0,32'h0,32'h0,32'h0};
    vecs[14] = '{1,1,1,1,1,0,32'h0,          1,2'b01,0,0,0,1,c_A0,c_W0,32'h0,32'h0};
    vecs[15] = '{1,1,1,1,1,1,32'h0000_ABCD,  0,2'b01,1,0,0,1,c_A0,c_W0,32'h0,32'h0};
    vecs[16] = '{1,0,0,1,1,0,32'h0,          0,2'b00,0,0,0,1,c_A0,c_W0,32'h0,32'h0};
    vecs[17] = '{1,0,0,1,1,0,32'h0,          1,2'b10,0,0,0,1,c_A1,c_W1,32'h0,32'h0};
    vecs[18] = '{1,0,0,1,1,1,32'h0,          0,2'b10,0,1,0,1,c_A1,c_W1,32'h0,32'h0};
    vecs[19] = '{1,0,0,0,0,0,32'h0,          0,2'b00,0,0,0,1,c_A1,c_W1,32'h0,32'h0};

    rst = 1'b0;
    m0_req = 0; m0_cmd = 0; m0_addr = c_A0; m0_wdata = c_W0;
    m1_req = 0; m1_cmd = 0; m1_addr = c_A1; m1_wdata = c_W1;
    s_ack = 0; s_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 chk("reset_state", outs(), 135'd0);

    for (int i = 0; i < c_NV; i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      m0_req = vecs[i].r0; m0_cmd = vecs[i].c0;
      m1_req = vecs[i].r1; m1_cmd = vecs[i].c1;
      s_ack = vecs[i].sack; s_rdata = vecs[i].srd;
      @(posedge clk);
      #1 chk($sformatf("vec%0d", i), outs(),
             {vecs[i].e_sreq, vecs[i].e_grant, vecs[i].e_ack0, vecs[i].e_ack1,
              vecs[i].e_err, vecs[i].e_scmd, vecs[i].e_saddr, vecs[i].e_swdata,
              vecs[i].e_rd0, vecs[i].e_rd1});
    end

    // Timeout: m0 read, slave silent; prio is 0 here and flips to 1.
    @(negedge clk);
    m0_req = 1; m0_cmd = 0; s_ack = 0; s_rdata = 32'h0;
    @(posedge clk);
    #1 chk("to_start", {s_req, grant}, {1'b1, 2'b01});
    n = 0; err_seen = 0; got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(posedge clk);
      #1;
      if (err) err_seen++;
      if (m0_ack) begin
        got = 1'b1;
        n = k;
      end
    end
    chk("to_latency", n, 16);
    chk("to_resp", {m0_rdata, err, s_req, m1_ack}, {32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    m0_req = 0;
    @(posedge clk);
    #1;
    if (err) err_seen++;
    chk("to_err_once", err_seen, 1);
    chk("to_release", {grant, m0_ack}, {2'b00, 1'b0});

    // Follow-up m0 write is still served; write leaves DEADBEEF in place.
    @(negedge clk);
    m0_req = 1; m0_cmd = 1;
    @(posedge clk);
    #1 chk("post_to_grant", {s_req, grant, s_cmd}, {1'b1, 2'b01, 1'b1});
    @(negedge clk);
    s_ack = 1; s_rdata = 32'h0BAD_0BAD;
    @(posedge clk);
    #1 chk("post_to_ack", {m0_ack, err, m0_rdata}, {1'b1, 1'b0, 32'hDEAD_BEEF});
    @(negedge clk);
    m0_req = 0; s_ack = 0;
    repeat (2) @(posedge clk);

    // Reset during BUSY on an m1 read; prio is 1 beforehand.
    @(negedge clk);
    m1_req = 1; m1_cmd = 0;
    @(posedge clk);
    #1 chk("rst_busy", {s_req, grant}, {1'b1, 2'b10});
    #3 rst = 1'b0;
    #1 chk("rst_immediate", outs(), 135'd0);
    m1_req = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    s_ack = 1; s_rdata = 32'h7777_7777;
    ack_seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (m0_ack || m1_ack || grant != 2'b00) ack_seen++;
    end
    chk("rst_no_ack", {ack_seen, m1_rdata}, {32'd0, 32'h0});
    @(negedge clk);
    s_ack = 0;
    m0_req = 1; m0_cmd = 1; m1_req = 1; m1_cmd = 1;
    @(posedge clk);
    #1 chk("rst_prio", {s_req, grant, s_addr}, {1'b1, 2'b01, c_A0});
    @(negedge clk);
    m0_req = 0; m1_req = 0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
